// File: rtl/regfile_banked.sv
// Banked CPU register file: PAIRS 16-bit pairs with byte/pair access, IDU, copy,
// masked flag updates and a shadow bank moved one pair per cycle by a small FSM.
module regfile_banked #(
    parameter int PAIRS     = 8,
    parameter int RD_PORTS  = 2,
    parameter int BYPASS    = 1,
    parameter int FLAG_BITS = 4,
    localparam int IW = $clog2(PAIRS)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [RD_PORTS-1:0]        rd_en_i,
    input  logic [RD_PORTS*(IW+1)-1:0] rd_idx_i,
    output logic [RD_PORTS*8-1:0]      rd_data_o,
    input  logic                       rd16_en_i,
    input  logic [IW-1:0]              rd16_pair_i,
    output logic [15:0]                rd16_data_o,
    input  logic                       wr8_en_i,
    input  logic [IW:0]                wr8_idx_i,
    input  logic [7:0]                 wr8_data_i,
    input  logic                       wr16_en_i,
    input  logic [IW-1:0]              wr16_pair_i,
    input  logic [15:0]                wr16_data_i,
    input  logic                       idu_en_i,
    input  logic [IW-1:0]              idu_pair_i,
    input  logic                       idu_dec_i,
    input  logic                       copy_en_i,
    input  logic [IW-1:0]              copy_src_i,
    input  logic [IW-1:0]              copy_dst_i,
    input  logic                       flags_we_i,
    input  logic [FLAG_BITS-1:0]       flags_mask_n_i,
    input  logic [FLAG_BITS-1:0]       flags_in_i,
    output logic [FLAG_BITS-1:0]       flags_out_o,
    output logic [7:0]                 a_out_o,
    input  logic                       bank_save_i,
    input  logic                       bank_restore_i,
    output logic                       bank_busy_o,
    output logic                       bank_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } state_e;

    // Unimplemented F bits are forced to zero on every update path.
    localparam logic [7:0] F_KEEP = 8'(8'hFF << (8 - FLAG_BITS));

    logic [15:0]          live_q   [PAIRS];
    logic [15:0]          live_d   [PAIRS];
    logic [15:0]          shadow_q [PAIRS];
    state_e               state_q;
    logic [IW-1:0]        cnt_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 wr16_ok_s, copy_ok_s, idu_ok_s, wr8_ok_s, flags_ok_s;
    logic [IW-1:0]        wr8_pair_s;
    logic                 wr8_hi_s;
    logic [15:0]          idu_val_s, copy_val_s;
    logic [FLAG_BITS-1:0] f_new_s;
    logic [7:0]           flags_byte_s;
    logic [IW-1:0]        rd_pair_s;
    logic                 rd_hi_s;
    logic [15:0]          view_s;

    function automatic logic in_range(input logic [IW-1:0] pair);
        return int'(pair) < PAIRS;
    endfunction

    // Qualify each live-write source; all of them are frozen while the bank FSM runs.
    always_comb begin
        wr8_pair_s = wr8_idx_i[IW:1];
        wr8_hi_s   = wr8_idx_i[0];
        wr16_ok_s  = wr16_en_i && !busy_q && in_range(wr16_pair_i);
        copy_ok_s  = copy_en_i && !busy_q && in_range(copy_src_i) && in_range(copy_dst_i)
                     && (copy_src_i != copy_dst_i);
        idu_ok_s   = idu_en_i && !busy_q && in_range(idu_pair_i);
        wr8_ok_s   = wr8_en_i && !busy_q && in_range(wr8_pair_s);
        flags_ok_s = flags_we_i && !busy_q;
        if (idu_ok_s) begin
            idu_val_s = idu_dec_i ? live_q[idu_pair_i] - 16'd1 : live_q[idu_pair_i] + 16'd1;
        end else begin
            idu_val_s = 16'd0;
        end
        if (copy_ok_s) begin
            copy_val_s = live_q[copy_src_i];
        end else begin
            copy_val_s = 16'd0;
        end
        f_new_s      = (live_q[0][7 -: FLAG_BITS] & flags_mask_n_i) | (flags_in_i & ~flags_mask_n_i);
        flags_byte_s = live_q[0][7:0];
        flags_byte_s[7 -: FLAG_BITS] = f_new_s;
    end

    // Per-byte next state: restore, then wr16 > copy > idu > wr8 > flags.
    always_comb begin
        live_d = live_q;
        for (int p = 0; p < PAIRS; p++) begin
            for (int b = 0; b < 2; b++) begin
                if (state_q == ST_RESTORE && cnt_q == IW'(p)) begin
                    live_d[p][b*8 +: 8] = shadow_q[p][b*8 +: 8];
                end else if (wr16_ok_s && wr16_pair_i == IW'(p)) begin
                    live_d[p][b*8 +: 8] = wr16_data_i[b*8 +: 8];
                end else if (copy_ok_s && copy_dst_i == IW'(p)) begin
                    live_d[p][b*8 +: 8] = copy_val_s[b*8 +: 8];
                end else if (idu_ok_s && idu_pair_i == IW'(p)) begin
                    live_d[p][b*8 +: 8] = idu_val_s[b*8 +: 8];
                end else if (wr8_ok_s && wr8_pair_s == IW'(p) && wr8_hi_s == b[0]) begin
                    live_d[p][b*8 +: 8] = wr8_data_i;
                end else if (flags_ok_s && p == 0 && b == 0) begin
                    live_d[p][b*8 +: 8] = flags_byte_s;
                end else begin
                    live_d[p][b*8 +: 8] = live_q[p][b*8 +: 8];
                end
            end
        end
        live_d[0][7:0] = live_d[0][7:0] & F_KEEP;
    end

    // Read ports; BYPASS selects between next-state and committed view.
    always_comb begin
        rd_data_o   = '0;
        rd16_data_o = 16'd0;
        rd_pair_s   = '0;
        rd_hi_s     = 1'b0;
        view_s      = 16'd0;
        for (int i = 0; i < RD_PORTS; i++) begin
            rd_pair_s = rd_idx_i[i*(IW+1)+1 +: IW];
            rd_hi_s   = rd_idx_i[i*(IW+1)];
            if (rd_en_i[i] && in_range(rd_pair_s)) begin
                view_s = (BYPASS != 0) ? live_d[rd_pair_s] : live_q[rd_pair_s];
                rd_data_o[i*8 +: 8] = rd_hi_s ? view_s[15:8] : view_s[7:0];
            end else begin
                rd_data_o[i*8 +: 8] = 8'd0;
            end
        end
        if (rd16_en_i && in_range(rd16_pair_i)) begin
            rd16_data_o = (BYPASS != 0) ? live_d[rd16_pair_i] : live_q[rd16_pair_i];
        end else begin
            rd16_data_o = 16'd0;
        end
    end

    // Live/shadow storage and the save/restore sequencer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < PAIRS; p++) begin
                live_q[p]   <= 16'd0;
                shadow_q[p] <= 16'd0;
            end
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            live_q <= live_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (bank_save_i) begin
                        state_q <= ST_SAVE;
                        busy_q  <= 1'b1;
                    end else if (bank_restore_i) begin
                        state_q <= ST_RESTORE;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SAVE, ST_RESTORE: begin
                    if (state_q == ST_SAVE) begin
                        shadow_q[cnt_q] <= live_q[cnt_q];
                    end
                    if (cnt_q == IW'(PAIRS - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign flags_out_o = live_q[0][7 -: FLAG_BITS];
    assign a_out_o     = live_q[0][15:8];
    assign bank_busy_o = busy_q;
    assign bank_done_o = done_q;

endmodule

// File: tb/tb_regfile_banked.sv
// Self-checking bench for regfile_banked: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_banked;

    localparam int PAIRS = 8;
    localparam int IW    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [7:0]  rd_idx;
    logic [15:0] rd_data;
    logic        rd16_en;
    logic [2:0]  rd16_pair;
    logic [15:0] rd16_data;
    logic        wr8_en;
    logic [3:0]  wr8_idx;
    logic [7:0]  wr8_data;
    logic        wr16_en;
    logic [2:0]  wr16_pair;
    logic [15:0] wr16_data;
    logic        idu_en;
    logic [2:0]  idu_pair;
    logic        idu_dec;
    logic        copy_en;
    logic [2:0]  copy_src;
    logic [2:0]  copy_dst;
    logic        flags_we;
    logic [3:0]  flags_mask_n;
    logic [3:0]  flags_in;
    logic [3:0]  flags_out;
    logic [7:0]  a_out;
    logic        bank_save;
    logic        bank_restore;
    logic        bank_busy;
    logic        bank_done;

    logic [15:0] m  [PAIRS];
    logic [15:0] sh [PAIRS];
    logic [15:0] nx [PAIRS];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_banked #(.PAIRS(PAIRS), .RD_PORTS(2), .BYPASS(1), .FLAG_BITS(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_en_i(rd_en), .rd_idx_i(rd_idx), .rd_data_o(rd_data),
        .rd16_en_i(rd16_en), .rd16_pair_i(rd16_pair), .rd16_data_o(rd16_data),
        .wr8_en_i(wr8_en), .wr8_idx_i(wr8_idx), .wr8_data_i(wr8_data),
        .wr16_en_i(wr16_en), .wr16_pair_i(wr16_pair), .wr16_data_i(wr16_data),
        .idu_en_i(idu_en), .idu_pair_i(idu_pair), .idu_dec_i(idu_dec),
        .copy_en_i(copy_en), .copy_src_i(copy_src), .copy_dst_i(copy_dst),
        .flags_we_i(flags_we), .flags_mask_n_i(flags_mask_n), .flags_in_i(flags_in),
        .flags_out_o(flags_out), .a_out_o(a_out),
        .bank_save_i(bank_save), .bank_restore_i(bank_restore),
        .bank_busy_o(bank_busy), .bank_done_o(bank_done)
    );

    task automatic idle();
        rd_en = 2'b00; rd_idx = 8'h00; rd16_en = 1'b0; rd16_pair = 3'd0;
        wr8_en = 1'b0; wr8_idx = 4'h0; wr8_data = 8'h00;
        wr16_en = 1'b0; wr16_pair = 3'd0; wr16_data = 16'h0000;
        idu_en = 1'b0; idu_pair = 3'd0; idu_dec = 1'b0;
        copy_en = 1'b0; copy_src = 3'd0; copy_dst = 3'd0;
        flags_we = 1'b0; flags_mask_n = 4'h0; flags_in = 4'h0;
        bank_save = 1'b0; bank_restore = 1'b0;
    endtask

    // Reference: apply sources lowest priority first so higher ones overwrite.
    task automatic predict();
        logic [3:0] f;
        for (int p = 0; p < PAIRS; p++) nx[p] = m[p];
        if (flags_we) begin
            f = m[0][7:4];
            nx[0][7:4] = (f & flags_mask_n) | (flags_in & ~flags_mask_n);
        end
        if (wr8_en) begin
            if (wr8_idx[0]) nx[wr8_idx[3:1]][15:8] = wr8_data;
            else            nx[wr8_idx[3:1]][7:0]  = wr8_data;
        end
        if (idu_en) nx[idu_pair] = idu_dec ? m[idu_pair] - 16'd1 : m[idu_pair] + 16'd1;
        if (copy_en && copy_src != copy_dst) nx[copy_dst] = m[copy_src];
        if (wr16_en) nx[wr16_pair] = wr16_data;
        nx[0][3:0] = 4'h0;
    endtask

    task automatic advance();
        @(posedge clk);
        for (int p = 0; p < PAIRS; p++) m[p] = nx[p];
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); idle(); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        for (int p = 0; p < PAIRS; p++) begin m[p] = 16'h0; sh[p] = 16'h0; end
        for (int p = 0; p < PAIRS; p++) begin
            @(negedge clk); idle();
            rd_en = 2'b11; rd_idx = {3'(p), 1'b1, 3'(p), 1'b0}; rd16_en = 1'b1; rd16_pair = 3'(p);
            #1;
            checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd pair %0d got %h exp 0000", p, rd_data); end
            checks++; if (rd16_data !== 16'h0000) begin errors++; $display("FAIL reset_rd16 pair %0d got %h exp 0000", p, rd16_data); end
        end
        checks++; if (flags_out !== 4'h0) begin errors++; $display("FAIL reset_flags got %h exp 0", flags_out); end
        checks++; if (a_out !== 8'h00) begin errors++; $display("FAIL reset_a got %h exp 00", a_out); end
        checks++; if (bank_busy !== 1'b0 || bank_done !== 1'b0) begin errors++; $display("FAIL reset_bank got busy=%b done=%b exp 0 0", bank_busy, bank_done); end
    endtask

    task automatic test_wr_priority();
        @(negedge clk); idle();
        wr16_en = 1'b1; wr16_pair = 3'd2; wr16_data = 16'h1234;
        wr8_en = 1'b1; wr8_idx = {3'd2, 1'b1}; wr8_data = 8'hAA;
        rd16_en = 1'b1; rd16_pair = 3'd2;
        predict(); #1;
        checks++; if (rd16_data !== 16'h1234) begin errors++; $display("FAIL wr16_bypass got %h exp 1234", rd16_data); end
        advance();
        @(negedge clk); idle(); rd16_en = 1'b1; rd16_pair = 3'd2; predict(); #1;
        checks++; if (rd16_data !== 16'h1234) begin errors++; $display("FAIL wr16_commit got %h exp 1234", rd16_data); end
        advance();
    endtask

    task automatic test_idu();
        @(negedge clk); idle(); wr16_en = 1'b1; wr16_pair = 3'd3; wr16_data = 16'hFFFF; predict(); advance();
        @(negedge clk); idle(); idu_en = 1'b1; idu_pair = 3'd3; idu_dec = 1'b0;
        rd16_en = 1'b1; rd16_pair = 3'd3; predict(); #1;
        checks++; if (rd16_data !== 16'h0000) begin errors++; $display("FAIL idu_inc_wrap got %h exp 0000", rd16_data); end
        advance();
        @(negedge clk); idle(); idu_en = 1'b1; idu_pair = 3'd3; idu_dec = 1'b1;
        rd16_en = 1'b1; rd16_pair = 3'd3; predict(); #1;
        checks++; if (rd16_data !== 16'hFFFF) begin errors++; $display("FAIL idu_dec_wrap got %h exp ffff", rd16_data); end
        advance();
        @(negedge clk); idle(); idu_en = 1'b1; idu_pair = 3'd3; idu_dec = 1'b0;
        wr8_en = 1'b1; wr8_idx = {3'd3, 1'b0}; wr8_data = 8'h55;
        rd_en = 2'b01; rd_idx = {3'd0, 1'b0, 3'd3, 1'b0}; predict(); #1;
        checks++; if (rd_data[7:0] !== 8'h00) begin errors++; $display("FAIL idu_over_wr8 got %h exp 00", rd_data[7:0]); end
        advance();
        @(negedge clk); idle(); rd16_en = 1'b1; rd16_pair = 3'd3; predict(); #1;
        checks++; if (rd16_data !== 16'h0000) begin errors++; $display("FAIL idu_over_wr8_commit got %h exp 0000", rd16_data); end
        advance();
    endtask

    task automatic test_flags();
        @(negedge clk); idle(); wr8_en = 1'b1; wr8_idx = {3'd0, 1'b0}; wr8_data = 8'hF0; predict(); advance();
        checks++; if (flags_out !== 4'hF) begin errors++; $display("FAIL flags_load got %h exp f", flags_out); end
        @(negedge clk); idle(); flags_we = 1'b1; flags_mask_n = 4'b0101; flags_in = 4'b0000; predict(); advance();
        checks++; if (flags_out !== 4'h5) begin errors++; $display("FAIL flags_mask got %h exp 5", flags_out); end
        @(negedge clk); idle(); wr16_en = 1'b1; wr16_pair = 3'd0; wr16_data = 16'h12FF; predict(); advance();
        checks++; if (flags_out !== 4'hF || a_out !== 8'h12) begin errors++; $display("FAIL af_wr16 got F=%h A=%h exp F=f A=12", flags_out, a_out); end
        @(negedge clk); idle(); rd16_en = 1'b1; rd16_pair = 3'd0; predict(); #1;
        checks++; if (rd16_data !== 16'h12F0) begin errors++; $display("FAIL af_low_nibble got %h exp 12f0", rd16_data); end
        advance();
    endtask

    task automatic test_random();
        logic [2:0] p;
        logic [7:0] exp8;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk); idle();
            rd_en = 2'($urandom); rd_idx = 8'($urandom);
            rd16_en = 1'($urandom); rd16_pair = 3'($urandom);
            wr8_en = 1'($urandom); wr8_idx = 4'($urandom_range(0, 7)); wr8_data = 8'($urandom);
            wr16_en = ($urandom_range(0, 3) == 0); wr16_pair = 3'($urandom_range(0, 3)); wr16_data = 16'($urandom);
            idu_en = ($urandom_range(0, 2) == 0); idu_pair = 3'($urandom_range(0, 3)); idu_dec = 1'($urandom);
            copy_en = ($urandom_range(0, 2) == 0); copy_src = 3'($urandom); copy_dst = 3'($urandom_range(0, 3));
            flags_we = 1'($urandom); flags_mask_n = 4'($urandom); flags_in = 4'($urandom);
            predict(); #1;
            for (int i = 0; i < 2; i++) begin
                p = rd_idx[i*4+1 +: 3];
                exp8 = !rd_en[i] ? 8'h00 : (rd_idx[i*4] ? nx[p][15:8] : nx[p][7:0]);
                checks++; if (rd_data[i*8 +: 8] !== exp8) begin errors++; $display("FAIL rand_rd%0d cyc %0d got %h exp %h", i, n, rd_data[i*8 +: 8], exp8); end
            end
            checks++; if (rd16_data !== (rd16_en ? nx[rd16_pair] : 16'h0000)) begin errors++; $display("FAIL rand_rd16 cyc %0d got %h exp %h", n, rd16_data, rd16_en ? nx[rd16_pair] : 16'h0000); end
            advance();
            checks++; if (flags_out !== m[0][7:4] || a_out !== m[0][15:8]) begin errors++; $display("FAIL rand_af cyc %0d got %h%h exp %h%h", n, a_out, flags_out, m[0][15:8], m[0][7:4]); end
        end
    endtask

    task automatic test_bank();
        for (int k = 0; k < PAIRS; k++) begin
            @(negedge clk); idle(); wr16_en = 1'b1; wr16_pair = 3'(k); wr16_data = 16'(k * 16'h1111); predict(); advance();
        end
        @(negedge clk); idle(); bank_save = 1'b1; predict(); advance();
        for (int p = 0; p < PAIRS; p++) sh[p] = m[p];
        for (int c = 0; c < PAIRS; c++) begin
            checks++; if (bank_busy !== 1'b1 || bank_done !== 1'b0) begin errors++; $display("FAIL save_busy cyc %0d got busy=%b done=%b exp 1 0", c, bank_busy, bank_done); end
            @(negedge clk); idle();
            wr16_en = 1'b1; wr16_pair = 3'(c); wr16_data = 16'hDEAD; bank_restore = 1'b1;
            flags_we = 1'b1; flags_mask_n = 4'h0; flags_in = 4'hA;
            rd16_en = 1'b1; rd16_pair = 3'(c); #1;
            checks++; if (rd16_data !== m[c]) begin errors++; $display("FAIL busy_wr_drop pair %0d got %h exp %h", c, rd16_data, m[c]); end
            @(posedge clk); #1;
        end
        checks++; if (bank_busy !== 1'b0 || bank_done !== 1'b1) begin errors++; $display("FAIL save_done got busy=%b done=%b exp 0 1", bank_busy, bank_done); end
        @(negedge clk); idle(); @(posedge clk); #1;
        checks++; if (bank_done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", bank_done); end
        for (int k = 0; k < PAIRS; k++) begin
            @(negedge clk); idle(); wr16_en = 1'b1; wr16_pair = 3'(k); wr16_data = 16'h0000; predict(); advance();
        end
        @(negedge clk); idle(); bank_restore = 1'b1; predict(); advance();
        for (int c = 0; c < PAIRS; c++) begin
            checks++; if (bank_busy !== 1'b1) begin errors++; $display("FAIL restore_busy cyc %0d got %b exp 1", c, bank_busy); end
            @(negedge clk); idle(); @(posedge clk); #1;
        end
        checks++; if (bank_done !== 1'b1) begin errors++; $display("FAIL restore_done got %b exp 1", bank_done); end
        for (int p = 0; p < PAIRS; p++) m[p] = sh[p];
        for (int p = 0; p < PAIRS; p++) begin
            @(negedge clk); idle(); rd16_en = 1'b1; rd16_pair = 3'(p); #1;
            checks++; if (rd16_data !== 16'(p * 16'h1111)) begin errors++; $display("FAIL restore_val pair %0d got %h exp %h", p, rd16_data, 16'(p * 16'h1111)); end
        end
    endtask

    task automatic test_reset_mid_save();
        @(negedge clk); idle(); bank_save = 1'b1; predict(); advance();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); idle(); predict(); advance();
        end
        @(negedge clk); idle(); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bank_busy !== 1'b0 || bank_done !== 1'b0) begin errors++; $display("FAIL midrst_bank got busy=%b done=%b exp 0 0", bank_busy, bank_done); end
        @(negedge clk); rst = 1'b0;
        for (int p = 0; p < PAIRS; p++) begin m[p] = 16'h0; sh[p] = 16'h0; end
        for (int c = 0; c < PAIRS + 2; c++) begin
            @(negedge clk); idle(); rd16_en = 1'b1; rd16_pair = 3'(c % PAIRS); #1;
            checks++; if (rd16_data !== 16'h0000) begin errors++; $display("FAIL midrst_clear pair %0d got %h exp 0000", c % PAIRS, rd16_data); end
            @(posedge clk); #1;
            checks++; if (bank_done !== 1'b0 || bank_busy !== 1'b0) begin errors++; $display("FAIL midrst_nodone cyc %0d got busy=%b done=%b exp 0 0", c, bank_busy, bank_done); end
        end
        @(negedge clk); idle(); wr16_en = 1'b1; wr16_pair = 3'd5; wr16_data = 16'hBEEF; predict(); advance();
        @(negedge clk); idle(); bank_restore = 1'b1; predict(); advance();
        for (int c = 0; c < PAIRS; c++) begin
            @(negedge clk); idle(); @(posedge clk); #1;
        end
        checks++; if (bank_done !== 1'b1) begin errors++; $display("FAIL midrst_restore_done got %b exp 1", bank_done); end
        @(negedge clk); idle(); rd16_en = 1'b1; rd16_pair = 3'd5; #1;
        checks++; if (rd16_data !== 16'h0000) begin errors++; $display("FAIL midrst_shadow_clear got %h exp 0000", rd16_data); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_wr_priority();
        test_idu();
        test_flags();
        test_random();
        test_bank();
        test_reset_mid_save();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
